program_loader: RTL



---
 rtl/program_loader_pkg.sv | 41 ++++
 rtl/program_loader_checksum.sv | 44 ++++
 rtl/program_loader.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// ---------------------------------------------------------------------------
// program_loader_pkg
// Shared definitions for the program loader: FSM state encodings, the frame
// selector byte values and small byte-arithmetic helpers used by both the
// loader FSM and its checksum accumulator.
// ---------------------------------------------------------------------------
package program_loader_pkg;

    typedef enum logic [3:0] {
        S_SEL  = 4'd0,
        S_AH   = 4'd1,
        S_AL   = 4'd2,
        S_LH   = 4'd3,
        S_LL   = 4'd4,
        S_PAY  = 4'd5,
        S_CHK  = 4'd6,
        S_DONE = 4'd7,
        S_ERR  = 4'd8
    } state_t;

    localparam logic [7:0] SEL_INST = 8'h49;
    localparam logic [7:0] SEL_DATA = 8'h44;
    localparam logic [7:0] SEL_END  = 8'h00;

    // 8-bit wrap-around add used for the payload checksum.
    function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

    // 8-bit increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'hFF) begin
            r = v;
        end else begin
            r = v + 8'h01;
        end
        return r;
    endfunction

endpackage

// File: rtl/program_loader_checksum.sv
// ---------------------------------------------------------------------------
// program_loader_checksum
// 8-bit running-sum accumulator for frame payloads.
// Ports:
//   CLK, CLR   clock and synchronous active-high reset
//   clear      zero the sum (start of a new frame)
//   add_en     add add_byte into the sum this cycle
//   add_byte   payload byte to accumulate
//   cmp_byte   byte to compare against the current sum
//   sum        current accumulated sum (registered)
//   match      1 when cmp_byte equals the current sum
// ---------------------------------------------------------------------------
module program_loader_checksum
    import program_loader_pkg::*;
(
    input  logic       CLK,
    input  logic       CLR,
    input  logic       clear,
    input  logic       add_en,
    input  logic [7:0] add_byte,
    input  logic [7:0] cmp_byte,
    output logic [7:0] sum,
    output logic       match
);

    logic [7:0] sum_r;

    // Running sum register: reset/clear to zero, otherwise accumulate on add_en.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            sum_r <= 8'h00;
        end else if (clear) begin
            sum_r <= 8'h00;
        end else if (add_en) begin
            sum_r <= sum8(sum_r, add_byte);
        end else begin
            sum_r <= sum_r;
        end
    end

    assign sum   = sum_r;
    assign match = (sum_r == cmp_byte);

endmodule

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
// Framed byte-stream writer that fills instruction and data RAM before the
// pipeline runs. Frames: SEL, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, payload, CHK.
// SEL 0x49 targets instruction RAM, 0x44 data RAM, 0x00 ends the load.
// Ports:
//   CLK, CLR            clock and synchronous active-high reset
//   in_valid/in_data    input byte stream, accepted when in_ready is high
//   in_ready            loader can take a byte this cycle
//   mem_addr/mem_data   shared RAM write port (registered)
//   inst_we/data_we     one-cycle write strobes for instruction/data RAM
//   cpu_hold            keep the pipeline cleared until loading completes
//   load_done           terminator frame accepted (sticky until CLR)
//   load_error          bad selector or checksum (sticky until CLR)
//   frame_cnt           good frames seen, saturating at 255
// ---------------------------------------------------------------------------
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              inst_we,
    output logic              data_we,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [7:0]        frame_cnt
);

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]  LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    state_t            next_state_s;

    logic              target_inst_r;
    logic [7:0]        addr_hi_r;
    logic [ADDR_W-1:0] addr_r;
    logic [7:0]        len_hi_r;
    logic [LEN_W-1:0]  len_r;
    logic [7:0]        frame_cnt_r;

    logic [ADDR_W-1:0] mem_addr_r;
    logic [7:0]        mem_data_r;
    logic              inst_we_r;
    logic              data_we_r;
    logic              in_ready_r;
    logic              cpu_hold_r;
    logic              load_done_r;
    logic              load_error_r;

    logic              accept_s;
    logic              cs_clear_s;
    logic              cs_add_s;
    logic              cs_match_s;
    logic [7:0]        cs_sum_s;
    logic              len_zero_s;

    assign accept_s   = in_valid & in_ready_r;
    // Length as it will be once LEN_LO is taken; decides PAY vs CHK.
    assign len_zero_s = ({len_hi_r, in_data} == 16'h0000);

    program_loader_checksum u_checksum (
        .CLK      (CLK),
        .CLR      (CLR),
        .clear    (cs_clear_s),
        .add_en   (cs_add_s),
        .add_byte (in_data),
        .cmp_byte (in_data),
        .sum      (cs_sum_s),
        .match    (cs_match_s)
    );

    // Next-state decode and checksum control; every transition needs an accepted byte.
    always_comb begin
        next_state_s = state_r;
        cs_clear_s   = 1'b0;
        cs_add_s     = 1'b0;
        case (state_r)
            S_SEL: begin
                if (accept_s) begin
                    cs_clear_s = 1'b1;
                    if ((in_data == SEL_INST) || (in_data == SEL_DATA)) begin
                        next_state_s = S_AH;
                    end else if (in_data == SEL_END) begin
                        next_state_s = S_DONE;
                    end else begin
                        next_state_s = S_ERR;
                    end
                end else begin
                    next_state_s = S_SEL;
                end
            end
            S_AH: begin
                if (accept_s) begin
                    next_state_s = S_AL;
                end else begin
                    next_state_s = S_AH;
                end
            end
            S_AL: begin
                if (accept_s) begin
                    next_state_s = S_LH;
                end else begin
                    next_state_s = S_AL;
                end
            end
            S_LH: begin
                if (accept_s) begin
                    next_state_s = S_LL;
                end else begin
                    next_state_s = S_LH;
                end
            end
            S_LL: begin
                if (accept_s) begin
                    if (len_zero_s) begin
                        next_state_s = S_CHK;
                    end else begin
                        next_state_s = S_PAY;
                    end
                end else begin
                    next_state_s = S_LL;
                end
            end
            S_PAY: begin
                if (accept_s) begin
                    cs_add_s = 1'b1;
                    if (len_r == LEN_ONE) begin
                        next_state_s = S_CHK;
                    end else begin
                        next_state_s = S_PAY;
                    end
                end else begin
                    next_state_s = S_PAY;
                end
            end
            S_CHK: begin
                if (accept_s) begin
                    if (cs_match_s) begin
                        next_state_s = S_SEL;
                    end else begin
                        next_state_s = S_ERR;
                    end
                end else begin
                    next_state_s = S_CHK;
                end
            end
            S_DONE: begin
                next_state_s = S_DONE;
            end
            S_ERR: begin
                next_state_s = S_ERR;
            end
            default: begin
                next_state_s = S_ERR;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_r <= S_SEL;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Frame header capture, length countdown and good-frame counter.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            target_inst_r <= 1'b0;
            addr_hi_r     <= 8'h00;
            addr_r        <= ADDR_ZERO;
            len_hi_r      <= 8'h00;
            len_r         <= LEN_ZERO;
            frame_cnt_r   <= 8'h00;
        end else if (accept_s) begin
            case (state_r)
                S_SEL: target_inst_r <= (in_data == SEL_INST);
                S_AH:  addr_hi_r     <= in_data;
                // Frame address is 16 bits; only the low ADDR_W bits address RAM.
                S_AL:  addr_r        <= ADDR_W'({addr_hi_r, in_data});
                S_LH:  len_hi_r      <= in_data;
                S_LL:  len_r         <= LEN_W'({len_hi_r, in_data});
                S_PAY: begin
                    addr_r <= addr_r + ADDR_ONE;
                    len_r  <= len_r - LEN_ONE;
                end
                S_CHK: begin
                    if (cs_match_s) begin
                        frame_cnt_r <= sat_inc8(frame_cnt_r);
                    end else begin
                        frame_cnt_r <= frame_cnt_r;
                    end
                end
                default: begin
                    addr_r <= addr_r;
                end
            endcase
        end else begin
            len_r <= len_r;
        end
    end

    // Write port: a payload byte accepted now is presented, with its strobe, next cycle.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            mem_addr_r <= ADDR_ZERO;
            mem_data_r <= 8'h00;
            inst_we_r  <= 1'b0;
            data_we_r  <= 1'b0;
        end else if (accept_s && (state_r == S_PAY)) begin
            mem_addr_r <= addr_r;
            mem_data_r <= in_data;
            inst_we_r  <= target_inst_r;
            data_we_r  <= ~target_inst_r;
        end else begin
            inst_we_r  <= 1'b0;
            data_we_r  <= 1'b0;
        end
    end

    // Status flags registered from the upcoming state so they line up with it.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            in_ready_r   <= 1'b1;
            cpu_hold_r   <= 1'b1;
            load_done_r  <= 1'b0;
            load_error_r <= 1'b0;
        end else begin
            in_ready_r   <= (next_state_s != S_DONE) && (next_state_s != S_ERR);
            cpu_hold_r   <= (next_state_s != S_DONE);
            load_done_r  <= (next_state_s == S_DONE);
            load_error_r <= (next_state_s == S_ERR);
        end
    end

    assign in_ready   = in_ready_r;
    assign mem_addr   = mem_addr_r;
    assign mem_data   = mem_data_r;
    assign inst_we    = inst_we_r;
    assign data_we    = data_we_r;
    assign cpu_hold   = cpu_hold_r;
    assign load_done  = load_done_r;
    assign load_error = load_error_r;
    assign frame_cnt  = frame_cnt_r;

endmodule
